// File: rtl/ysyx_24080006_mem_arbiter_pkg.sv
// Shared types and constants for the core memory arbiter and its helpers.
//   N_MST       : number of memory requesters (0 = IFU, 1 = LSU)
//   MEM_AW/DW   : address / data width of the core memory port
//   fsm_e       : arbiter sequencing states
//   axi_resp_e  : AXI4-Lite response encodings
//   mem_req_t   : request latched at grant time
//   resp_is_err : true for any response other than OKAY
package ysyx_24080006_mem_arbiter_pkg;

    localparam int N_MST  = 2;
    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;
    localparam int MEM_SW = MEM_DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } fsm_e;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
        logic [MEM_SW-1:0] wstrb;
    } mem_req_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (axi_resp_e'(resp) != OKAY);
    endfunction

endpackage

// File: rtl/ysyx_24080006_rr_pick.sv
// Combinational round-robin picker.
//   req      : in  N   request vector
//   last_gnt : in  IW  index of the most recently served requester
//   gnt      : out N   one-hot pick, searching from last_gnt+1 with wrap
module ysyx_24080006_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_gnt,
    output logic [N-1:0]  gnt
);

    int   idx_s;
    logic found_s;

    // Walk the requesters starting just after the last winner; the first set bit wins.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 1; k <= N; k++) begin
            idx_s = (int'(last_gnt) + k) % N;
            if (!found_s && req[idx_s[IW-1:0]]) begin
                gnt[idx_s[IW-1:0]] = 1'b1;
                found_s            = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/ysyx_24080006_mem_arbiter.sv
// Round-robin arbiter sharing the core's single AXI4-Lite port between
// N_MST simple request/response masters. One transaction outstanding at a time.
//   clock, reset_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready            : per-master request handshake (ready one-hot, IDLE only)
//   req_we/addr/wdata/wstrb        : per-master request payload, master i at [i*W +: W]
//   rsp_valid                      : one-cycle response pulse to the served master
//   rsp_rdata, rsp_err             : shared read data, non-OKAY flag
//   ar*/r*/aw*/w*/b*               : AXI4-Lite master channels
module ysyx_24080006_mem_arbiter
    import ysyx_24080006_mem_arbiter_pkg::*;
#(
    parameter int N_MST = ysyx_24080006_mem_arbiter_pkg::N_MST,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_MST-1:0]        req_valid,
    output logic [N_MST-1:0]        req_ready,
    input  logic [N_MST-1:0]        req_we,
    input  logic [N_MST*AW-1:0]     req_addr,
    input  logic [N_MST*DW-1:0]     req_wdata,
    input  logic [N_MST*DW/8-1:0]   req_wstrb,
    output logic [N_MST-1:0]        rsp_valid,
    output logic [DW-1:0]           rsp_rdata,
    output logic                    rsp_err,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [AW-1:0]           araddr,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DW-1:0]           rdata,
    input  logic [1:0]              rresp,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [AW-1:0]           awaddr,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DW-1:0]           wdata,
    output logic [DW/8-1:0]         wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp
);

    localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int SW = DW / 8;

    fsm_e             state_r;
    logic [IW-1:0]    last_gnt_r;
    logic [IW-1:0]    gnt_r;
    mem_req_t         req_r;
    logic             aw_done_r;
    logic             w_done_r;

    logic [N_MST-1:0] pick_s;
    logic [IW-1:0]    pick_idx_s;
    mem_req_t         sel_req_s;
    logic [N_MST-1:0] gnt_onehot_s;
    logic             aw_fire_s;
    logic             w_fire_s;
    logic             aw_all_s;
    logic             w_all_s;

    ysyx_24080006_rr_pick #(
        .N  (N_MST),
        .IW (IW)
    ) u_rr_pick (
        .req      (req_valid),
        .last_gnt (last_gnt_r),
        .gnt      (pick_s)
    );

    // Convert the one-hot pick into an index for payload selection.
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (pick_s[i]) begin
                pick_idx_s = IW'(i);
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Route the picked master's payload into the request record.
    always_comb begin
        sel_req_s       = '0;
        sel_req_s.we    = req_we[pick_idx_s];
        sel_req_s.addr  = req_addr[pick_idx_s*AW +: AW];
        sel_req_s.wdata = req_wdata[pick_idx_s*DW +: DW];
        sel_req_s.wstrb = req_wstrb[pick_idx_s*SW +: SW];
    end

    // Offer the grant only in IDLE; gating with reset_n keeps it low while reset is held.
    always_comb begin
        if (reset_n && (state_r == IDLE)) begin
            req_ready = pick_s;
        end else begin
            req_ready = '0;
        end
    end

    // One-hot form of the latched grant for the response pulse.
    always_comb begin
        gnt_onehot_s = '0;
        for (int i = 0; i < N_MST; i++) begin
            gnt_onehot_s[i] = (gnt_r == IW'(i));
        end
    end

    // Write-channel progress: address and data complete independently, possibly together.
    always_comb begin
        aw_fire_s = awvalid & awready;
        w_fire_s  = wvalid & wready;
        aw_all_s  = aw_done_r | aw_fire_s;
        w_all_s   = w_done_r | w_fire_s;
    end

    // Address and data outputs come straight from the latched request register.
    assign araddr = req_r.addr;
    assign awaddr = req_r.addr;
    assign wdata  = req_r.wdata;
    assign wstrb  = req_r.wstrb;

    // Sequencer: grant, drive the AXI channels, collect the response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            last_gnt_r <= IW'(N_MST - 1);
            gnt_r      <= '0;
            req_r      <= '0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (|pick_s) begin
                        gnt_r     <= pick_idx_s;
                        req_r     <= sel_req_s;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        if (sel_req_s.we) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            arvalid <= 1'b1;
                        end
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    if (req_r.we) begin
                        if (aw_fire_s) begin
                            awvalid   <= 1'b0;
                            aw_done_r <= 1'b1;
                        end
                        if (w_fire_s) begin
                            wvalid   <= 1'b0;
                            w_done_r <= 1'b1;
                        end
                        if (aw_all_s && w_all_s) begin
                            bready  <= 1'b1;
                            state_r <= WAIT;
                        end
                    end else begin
                        if (arready) begin
                            arvalid <= 1'b0;
                            rready  <= 1'b1;
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (req_r.we) begin
                        if (bvalid) begin
                            bready     <= 1'b0;
                            rsp_err    <= resp_is_err(bresp);
                            rsp_valid  <= gnt_onehot_s;
                            last_gnt_r <= gnt_r;
                            state_r    <= IDLE;
                        end
                    end else begin
                        if (rvalid) begin
                            rready     <= 1'b0;
                            rsp_rdata  <= rdata;
                            rsp_err    <= resp_is_err(rresp);
                            rsp_valid  <= gnt_onehot_s;
                            last_gnt_r <= gnt_r;
                            state_r    <= IDLE;
                        end
                    end
                end
                default: begin
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    bready  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mem_arbiter.sv
// Directed self-checking bench for ysyx_24080006_mem_arbiter with a small
// configurable AXI4-Lite slave (per-channel ready wait, zero-wait responses).
module tb_ysyx_24080006_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*DW/8-1:0] req_wstrb;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            arvalid;
    logic            arready = 1'b0;
    logic [AW-1:0]   araddr;
    logic            rvalid = 1'b0;
    logic            rready;
    logic [DW-1:0]   rdata = '0;
    logic [1:0]      rresp = 2'b00;
    logic            awvalid;
    logic            awready = 1'b0;
    logic [AW-1:0]   awaddr;
    logic            wvalid;
    logic            wready = 1'b0;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid = 1'b0;
    logic            bready;
    logic [1:0]      bresp = 2'b00;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    // slave configuration
    int          ar_wait = 0;
    int          aw_wait = 0;
    int          w_wait  = 0;
    int          ar_cnt  = 0;
    int          aw_cnt  = 0;
    int          w_cnt   = 0;
    logic [31:0] r_data  = 32'h0;
    logic [1:0]  r_resp  = 2'b00;
    logic [1:0]  b_resp  = 2'b00;
    logic        rv_force = 1'b0;

    always #5 clock = ~clock;

    ysyx_24080006_mem_arbiter #(.N_MST(N), .AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp)
    );

    // Slave model: ready after N waiting cycles, response data the cycle ready is seen.
    always @(negedge clock) begin
        if (arvalid) begin
            arready = (ar_cnt >= ar_wait);
            ar_cnt++;
        end else begin
            arready = 1'b0;
            ar_cnt  = 0;
        end
        if (awvalid) begin
            awready = (aw_cnt >= aw_wait);
            aw_cnt++;
        end else begin
            awready = 1'b0;
            aw_cnt  = 0;
        end
        if (wvalid) begin
            wready = (w_cnt >= w_wait);
            w_cnt++;
        end else begin
            wready = 1'b0;
            w_cnt  = 0;
        end
        rvalid = rready | rv_force;
        rdata  = r_data;
        rresp  = r_resp;
        bvalid = bready;
        bresp  = b_resp;
    end

    // Grant sanity: never two readies, never a grant while a transaction is in flight.
    always @(negedge clock) begin
        #1;
        if (req_ready == 2'b11) viol++;
        if ((req_ready != 2'b00) && (arvalid | awvalid | wvalid | rready | bready)) viol++;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while ((rsp_valid == 2'b00) && (n < 50)) begin
            step();
            n++;
        end
        check_eq({tag, "_rsp_seen"}, 64'(|rsp_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'h0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check_eq("rst_arvalid",   64'(arvalid),   64'h0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);

        // T1: single IFU read, zero-wait slave
        step();
        req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h8000_0000;
        r_data = 32'h0000_0413; r_resp = 2'b00;
        #1;
        check_eq("t1_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        check_eq("t1_arvalid", 64'(arvalid), 64'h1);
        check_eq("t1_araddr",  64'(araddr),  64'h8000_0000);
        step();
        check_eq("t1_rready",     64'(rready),  64'h1);
        check_eq("t1_arvalid_lo", 64'(arvalid), 64'h0);
        step();
        check_eq("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        check_eq("t1_rsp_rdata", 64'(rsp_rdata), 64'h0000_0413);
        check_eq("t1_rsp_err",   64'(rsp_err),   64'h0);
        step();
        check_eq("t1_rsp_pulse", 64'(rsp_valid), 64'h0);

        // T2: LSU write, awready two cycles ahead of wready
        step();
        req_valid = 2'b10; req_we = 2'b10;
        req_addr[63:32] = 32'h8000_1000; req_wdata[63:32] = 32'hDEAD_BEEF; req_wstrb[7:4] = 4'b0011;
        aw_wait = 0; w_wait = 2; b_resp = 2'b00;
        #1;
        check_eq("t2_ready", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        check_eq("t2_awvalid", 64'(awvalid), 64'h1);
        check_eq("t2_wvalid",  64'(wvalid),  64'h1);
        check_eq("t2_awaddr",  64'(awaddr),  64'h8000_1000);
        check_eq("t2_wdata",   64'(wdata),   64'hDEAD_BEEF);
        check_eq("t2_wstrb",   64'(wstrb),   64'h3);
        step();
        check_eq("t2_aw_dropped", 64'(awvalid), 64'h0);
        check_eq("t2_w_held1",    64'(wvalid),  64'h1);
        step();
        check_eq("t2_w_held2", 64'(wvalid), 64'h1);
        step();
        check_eq("t2_bready",    64'(bready), 64'h1);
        check_eq("t2_w_dropped", 64'(wvalid), 64'h0);
        step();
        check_eq("t2_rsp_valid", 64'(rsp_valid), 64'h2);
        check_eq("t2_rsp_err",   64'(rsp_err),   64'h0);
        check_eq("t2_rdata_kept", 64'(rsp_rdata), 64'h0000_0413);
        w_wait = 0;

        // T3: both masters requesting continuously alternate
        step();
        req_valid = 2'b11; req_we = 2'b00;
        req_addr  = {32'h0000_0200, 32'h0000_0100};
        #1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0]  exp_g;
            logic [31:0] exp_a;
            exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_a  = (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            r_data = 32'h0000_00A0 + 32'(k);
            check_eq("t3_grant", 64'(req_ready), 64'(exp_g));
            step();
            check_eq("t3_araddr", 64'(araddr), 64'(exp_a));
            wait_rsp("t3");
            check_eq("t3_rsp_valid", 64'(rsp_valid), 64'(exp_g));
            check_eq("t3_rsp_rdata", 64'(rsp_rdata), 64'(32'h0000_00A0 + 32'(k)));
        end
        req_valid = 2'b00;

        // T4: SLVERR read, stray rvalid in IDLE, then a normal request
        r_resp = 2'b10; r_data = 32'h0000_0BAD;
        step();
        req_valid = 2'b01; req_addr[31:0] = 32'h0000_0300;
        #1;
        check_eq("t4_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        wait_rsp("t4");
        check_eq("t4_rsp_valid", 64'(rsp_valid), 64'h1);
        check_eq("t4_rsp_err",   64'(rsp_err),   64'h1);
        check_eq("t4_rsp_rdata", 64'(rsp_rdata), 64'h0000_0BAD);
        step();
        check_eq("t4_err_pulse", 64'(rsp_err),   64'h0);
        check_eq("t4_rsp_pulse", 64'(rsp_valid), 64'h0);
        rv_force = 1'b1;
        step();
        step();
        check_eq("t4_stray_rready", 64'(rready),    64'h0);
        check_eq("t4_stray_rsp",    64'(rsp_valid), 64'h0);
        rv_force = 1'b0;
        step();
        r_resp = 2'b00; r_data = 32'h0000_0055;
        req_valid = 2'b10; req_we = 2'b00; req_addr[63:32] = 32'h0000_0400;
        #1;
        check_eq("t4_next_ready", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        wait_rsp("t4n");
        check_eq("t4_next_rsp",   64'(rsp_valid), 64'h2);
        check_eq("t4_next_err",   64'(rsp_err),   64'h0);
        check_eq("t4_next_rdata", 64'(rsp_rdata), 64'h0000_0055);

        // T5: arready withheld for 5 cycles while LSU waits
        ar_wait = 5; r_data = 32'h0000_0077;
        step();
        req_valid = 2'b11; req_addr = {32'h0000_0600, 32'h0000_0500};
        #1;
        check_eq("t5_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b10;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_arvalid_hold", 64'(arvalid),   64'h1);
            check_eq("t5_araddr_hold",  64'(araddr),    64'h0000_0500);
            check_eq("t5_no_ready",     64'(req_ready), 64'h0);
            step();
        end
        ar_wait = 0;
        wait_rsp("t5");
        check_eq("t5_rsp_valid", 64'(rsp_valid), 64'h1);
        check_eq("t5_rsp_rdata", 64'(rsp_rdata), 64'h0000_0077);
        check_eq("t5_lsu_next",  64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        wait_rsp("t5l");
        check_eq("t5_lsu_rsp", 64'(rsp_valid), 64'h2);

        // T6: asynchronous reset while waiting on a pending read response
        r_data = 32'h0000_0099;
        step();
        req_valid = 2'b01; req_addr[31:0] = 32'h0000_0700;
        step();
        req_valid = 2'b00;
        step();
        check_eq("t6_in_wait", 64'(rready), 64'h1);
        #2;
        reset_n   = 1'b0;
        req_valid = 2'b11;
        #1;
        check_eq("t6_rst_ctrl", {54'd0, req_ready, rsp_valid, rsp_err, arvalid, rready, awvalid, wvalid, bready}, 64'h0);
        check_eq("t6_rst_addr", {araddr, awaddr}, 64'h0);
        check_eq("t6_rst_data", {rsp_rdata, wdata}, 64'h0);
        check_eq("t6_rst_wstrb", 64'(wstrb), 64'h0);
        step();
        step();
        check_eq("t6_held_ready", 64'(req_ready), 64'h0);
        reset_n = 1'b1;
        #1;
        check_eq("t6_first_grant", 64'(req_ready), 64'h1);
        check_eq("t6_no_stale0",   64'(rsp_valid), 64'h0);
        step();
        req_valid = 2'b00;
        check_eq("t6_no_stale1", 64'(rsp_valid), 64'h0);
        check_eq("t6_arvalid",   64'(arvalid),   64'h1);
        check_eq("t6_araddr",    64'(araddr),    64'h0000_0700);
        wait_rsp("t6");
        check_eq("t6_rsp_valid", 64'(rsp_valid), 64'h1);
        check_eq("t6_rsp_rdata", 64'(rsp_rdata), 64'h0000_0099);

        check_eq("grant_sanity", 64'(viol), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24080006_mem_arbiter.md
Name: ysyx_24080006_mem_arbiter

Overview:
- Sequences the core's single AXI4-Lite memory port and shares it between N_MST requesters: master 0 is the IFU/icache refill, master 1 is the LSU.
- Masters use a simple request/response interface. The block grants one master round-robin, drives the slave channels for that master, and returns the response to it.
- Exactly one transaction is outstanding at a time.

Parameters:
- N_MST, 2, number of requesters (index 0 = IFU, 1 = LSU).
- AW, 32, address width.
- DW, 32, data width (wstrb width DW/8).

Ports:
- clock  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_MST  per-master request valid.
- req_ready  out  N_MST  per-master request accepted (one-hot).
- req_we  in  N_MST  1 = write, 0 = read.
- req_addr  in  N_MST*AW  per-master address, master i at bits [i*AW +: AW].
- req_wdata  in  N_MST*DW  per-master write data.
- req_wstrb  in  N_MST*DW/8  per-master byte strobes.
- rsp_valid  out  N_MST  one-cycle response pulse to the granted master.
- rsp_rdata  out  DW  read data, shared by all masters.
- rsp_err  out  1  response was not OKAY.
- arvalid/arready  out/in  1  AXI read address handshake.
- araddr  out  AW  AXI read address.
- rvalid/rready  in/out  1  AXI read data handshake.
- rdata  in  DW  AXI read data.
- rresp  in  2  AXI read response.
- awvalid/awready  out/in  1  AXI write address handshake.
- awaddr  out  AW  AXI write address.
- wvalid/wready  out/in  1  AXI write data handshake.
- wdata  out  DW  AXI write data.
- wstrb  out  DW/8  AXI write strobes.
- bvalid/bready  in/out  1  AXI write response handshake.
- bresp  in  2  AXI write response.

Behaviour:
- FSM uses fsm_e: IDLE, EXEC, WAIT.
- Reset: state = IDLE, last_gnt = N_MST-1 so master 0 wins first. Every output is 0, including rsp_rdata.
- Reset is asynchronous. Asserting it mid-transaction aborts the transaction immediately, all outputs go to 0, and nothing is replayed.
- IDLE:
  - Round-robin pick among set req_valid bits, searching from last_gnt+1 with wrap-around.
  - req_ready = onehot(pick), combinational, asserted only in IDLE.
  - On the handshake edge: latch we/addr/wdata/wstrb and gnt, then go to EXEC.
  - No req_valid: stay in IDLE with no ready asserted.
- EXEC, read: arvalid = 1 with araddr latched. On arvalid&arready, go to WAIT.
- EXEC, write:
  - awvalid and wvalid rise together.
  - Each drops independently after its own handshake, tracked by aw_done/w_done flags.
  - Go to WAIT when both are done; this can be the same cycle.
  - wstrb = 0 is still issued.
- AXI outputs hold stable while valid is high and ready is low.
- WAIT:
  - rready (read) or bready (write) = 1.
  - On rvalid/bvalid: register rsp_rdata = rdata (reads only; writes leave it unchanged), rsp_err = (resp != 2'b00), rsp_valid[gnt] = 1 for exactly one cycle. Update last_gnt = gnt and go to IDLE.
- Masters cannot backpressure responses.
- rsp_valid is high in the same cycle the FSM is back in IDLE, so a new grant may coincide with it.
- Minimum latency with zero-wait slave: req handshake at cycle 0, AR handshake at cycle 1, R at cycle 2, rsp_valid at cycle 3.
- A requester not granted must hold its req_valid and payload stable. The arbiter never drops a pending request.
- Simultaneous requests alternate strictly, so an IFU stream cannot starve the LSU or vice versa.
- Unexpected rvalid/bvalid outside WAIT is ignored (rready/bready = 0).

Decomposition:
- Shared package additions:
  - N_MST.
  - axi_resp_e (OKAY = 0, EXOKAY, SLVERR, DECERR).
  - mem_req_t packed struct {we, addr[31:0], wdata[31:0], wstrb[3:0]} for the latched request.
  - Reuse fsm_e unchanged.
- One natural sub-module: ysyx_24080006_rr_pick. It is combinational; inputs are req vector and last_gnt, output is a one-hot grant. It is reused later by the CLINT/UART bridge.

Test Plan:
- Single IFU read of 0x8000_0000, slave returns rdata 0x0000_0413 with zero wait and OKAY -> arvalid at cycle 1 with araddr 0x8000_0000; rsp_valid = 2'b01 at cycle 3 with rsp_rdata 0x0000_0413 and rsp_err 0.
- LSU write addr 0x8000_1000, wdata 0xDEAD_BEEF, wstrb 4'b0011; slave asserts awready 2 cycles before wready -> awvalid drops first, wvalid holds until its handshake; bready, then rsp_valid = 2'b10.
- Both masters hold req_valid for 4 back-to-back transactions -> grants go IFU, LSU, IFU, LSU; at most one outstanding transaction; req_ready is never high for both masters at once.
- Read with rresp = 2'b10 (SLVERR) -> rsp_err = 1 for one cycle, FSM returns to IDLE, and the next request proceeds normally.
- reset_n pulled low in WAIT with rvalid pending -> all outputs 0 without waiting for a clock edge; after release, the first grant goes to master 0 and no stale rsp_valid appears.
- Slave holds arready = 0 for 5 cycles -> arvalid and araddr stay stable throughout and no other master receives req_ready.
